// File: rtl/mouse_pkg.sv
// Shared constants and types for the mouse peripherals on the 8-bit processor bus.
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH,
    ST_ERROR
  } sens_state_e;

  typedef logic [7:0] bus_word_t;

  localparam bus_word_t MOUSE_BASE = 8'hA0;
  localparam bus_word_t SENS_BASE  = 8'hA6;

  // STATUS register layout: {BUSY, err, done, 0, TARGET[1:0], SENS_CUR[1:0]}
  localparam int STAT_BUSY   = 7;
  localparam int STAT_ERR    = 6;
  localparam int STAT_DONE   = 5;
  localparam int STAT_TGT_LO = 2;
  localparam int STAT_CUR_LO = 0;

  localparam int INT_MOUSE = 0;
  localparam int INT_SENS  = 1;

endpackage

// File: rtl/bus_reg_port.sv
// Address decode, write strobes and registered read-back for a small window of bus registers.
module bus_reg_port
  import mouse_pkg::*;
#(
  parameter bus_word_t BASE     = 8'h00,
  parameter int        NUM_REGS = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  inout  wire  [7:0]                 BUS_DATA,
  input  logic [7:0]                 BUS_ADDR,
  input  logic                       BUS_WE,
  input  bus_word_t [NUM_REGS-1:0]   rd_regs,
  output logic [NUM_REGS-1:0]        wr_stb
);

  localparam int        IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam bus_word_t NREG = 8'(NUM_REGS);

  logic [7:0]    off;
  logic          hit;
  logic [IW-1:0] idx;
  logic          drv;
  bus_word_t     rd_q;

  assign off = BUS_ADDR - BASE;
  assign hit = (off < NREG);
  assign idx = off[IW-1:0];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_wr
    assign wr_stb[g] = BUS_WE && (off == 8'(g));
  end

  // Data is captured in the address cycle and presented for exactly the next one.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      drv  <= 1'b0;
      rd_q <= '0;
    end else begin
      drv <= hit && !BUS_WE;
      if (hit && !BUS_WE) rd_q <= rd_regs[idx];
    end
  end

  assign BUS_DATA = drv ? rd_q : 8'hZZ;

endmodule

// File: rtl/mouse_sens_ctrl.sv
// Steps the mouse transceiver's sensitivity toward a software target one INC/RED pulse at a
// time, waiting for each step to show up on SENS_CUR, and interrupts on completion or timeout.
module mouse_sens_ctrl
  import mouse_pkg::*;
#(
  parameter bus_word_t   BASE_ADDR      = SENS_BASE,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int          INT_IDX        = INT_SENS
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [1:0] SENS_CUR,
  output logic       INC_SENS,
  output logic       RED_SENS,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic [1:0] BUS_INTERRUPTS_ACK,
  output logic       BUSY
);

  sens_state_e state, state_nxt;

  logic [1:0]  target, snap;
  logic        pending, done, err, dir, raise;
  logic [23:0] timer;

  logic [1:0]            wr_stb;
  bus_word_t [1:0]       rd_regs;

  logic take_pending, latch_snap, ld_timer, dec_timer, set_done, set_err;

  bus_reg_port #(.BASE(BASE_ADDR), .NUM_REGS(2)) u_port (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUS_DATA (BUS_DATA),
    .BUS_ADDR (BUS_ADDR),
    .BUS_WE   (BUS_WE),
    .rd_regs  (rd_regs),
    .wr_stb   (wr_stb)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    take_pending = 1'b0;
    latch_snap   = 1'b0;
    ld_timer     = 1'b0;
    dec_timer    = 1'b0;
    set_done     = 1'b0;
    set_err      = 1'b0;
    case (state)
      ST_IDLE: if (pending) begin
        take_pending = 1'b1;
        state_nxt    = ST_COMPARE;
      end
      ST_COMPARE: if (target == SENS_CUR) state_nxt = ST_FINISH;
                  else begin
                    latch_snap = 1'b1;
                    state_nxt  = ST_ISSUE;
                  end
      ST_ISSUE: begin
        ld_timer  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (SENS_CUR != snap) state_nxt = ST_COMPARE;
               else if (timer == '0)  state_nxt = ST_ERROR;
               else                   dec_timer = 1'b1;
      ST_FINISH: begin
        set_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        set_err   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sets take priority over clears on every flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      target  <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      raise   <= 1'b0;
      snap    <= '0;
      dir     <= 1'b0;
      timer   <= '0;
    end else begin
      if (wr_stb[0]) target <= BUS_DATA[1:0];

      if (wr_stb[0])         pending <= 1'b1;
      else if (take_pending) pending <= 1'b0;

      if (set_done)       done <= 1'b1;
      else if (wr_stb[1]) done <= 1'b0;

      if (set_err)        err <= 1'b1;
      else if (wr_stb[1]) err <= 1'b0;

      if (set_done || set_err)              raise <= 1'b1;
      else if (BUS_INTERRUPTS_ACK[INT_IDX]) raise <= 1'b0;

      if (latch_snap) begin
        snap <= SENS_CUR;
        dir  <= (target > SENS_CUR);
      end

      if (ld_timer)       timer <= TIMEOUT_CYCLES - 24'd1;
      else if (dec_timer) timer <= timer - 24'd1;
    end
  end

  assign BUSY                = (state != ST_IDLE);
  assign BUS_INTERRUPT_RAISE = raise;
  // Gated by RESET so a reset landing on the ISSUE cycle never leaks a step.
  assign INC_SENS            = RESET && (state == ST_ISSUE) && dir;
  assign RED_SENS            = RESET && (state == ST_ISSUE) && !dir;

  always_comb begin
    rd_regs                       = '0;
    rd_regs[0][1:0]               = target;
    rd_regs[1][STAT_BUSY]         = BUSY;
    rd_regs[1][STAT_ERR]          = err;
    rd_regs[1][STAT_DONE]         = done;
    rd_regs[1][STAT_TGT_LO +: 2]  = target;
    rd_regs[1][STAT_CUR_LO +: 2]  = SENS_CUR;
  end

  // Only the ACK bit at INT_IDX belongs to this block.
  logic unused_ack;
  assign unused_ack = &{1'b0, BUS_INTERRUPTS_ACK};

endmodule

// File: tb/tb_mouse_sens_ctrl.sv
// Self-checking bench for mouse_sens_ctrl: directed scenarios plus randomized retargeting.
module tb_mouse_sens_ctrl;
  import mouse_pkg::*;

  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  wire  [7:0] BUS_DATA;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic [1:0] SENS_CUR;
  logic       INC_SENS, RED_SENS, BUS_INTERRUPT_RAISE, BUSY;
  logic [1:0] BUS_INTERRUPTS_ACK = 2'b00;

  logic [7:0] tb_dat = 8'h00;
  logic       tb_drv = 1'b0;
  assign BUS_DATA = tb_drv ? tb_dat : 8'hZZ;

  // Transceiver: main process owns sens_base, the transceiver model owns sens_delta.
  logic [1:0] sens_base = 2'd0;
  logic [1:0] sens_delta = 2'd0;
  assign SENS_CUR = sens_base + sens_delta;

  bit respond = 1'b1;
  int inc_cnt = 0, red_cnt = 0;
  bit both_seen = 1'b0;
  int vectors = 0, errs = 0;

  mouse_sens_ctrl #(.BASE_ADDR(8'hA6), .TIMEOUT_CYCLES(24'(TMO)), .INT_IDX(1)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .BUS_DATA            (BUS_DATA),
    .BUS_ADDR            (BUS_ADDR),
    .BUS_WE              (BUS_WE),
    .SENS_CUR            (SENS_CUR),
    .INC_SENS            (INC_SENS),
    .RED_SENS            (RED_SENS),
    .BUS_INTERRUPT_RAISE (BUS_INTERRUPT_RAISE),
    .BUS_INTERRUPTS_ACK  (BUS_INTERRUPTS_ACK),
    .BUSY                (BUSY)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor and transceiver: a step lands 5 cycles after its pulse.
  initial begin : xcvr
    int  dly;
    bit  up;
    dly = 0;
    up  = 1'b0;
    forever begin
      @(negedge CLK);
      if (INC_SENS) inc_cnt++;
      if (RED_SENS) red_cnt++;
      if (INC_SENS && RED_SENS) both_seen = 1'b1;
      if (dly > 0) begin
        dly--;
        if (dly == 0) sens_delta = up ? sens_delta + 2'd1 : sens_delta - 2'd1;
      end
      if ((INC_SENS || RED_SENS) && respond && RESET) begin
        dly = 5;
        up  = INC_SENS;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b1; tb_dat = d; tb_drv = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0; tb_drv = 1'b0; BUS_ADDR = 8'h00;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b0;
    @(negedge CLK);
    d = BUS_DATA;
    BUS_ADDR = 8'h00;
  endtask

  task automatic ack();
    BUS_INTERRUPTS_ACK = 2'b10;
    @(negedge CLK);
    BUS_INTERRUPTS_ACK = 2'b00;
  endtask

  task automatic set_sens(input int v);
    sens_base = 2'(v) - sens_delta;
  endtask

  task automatic wait_idle(input string tag);
    int streak, n;
    streak = 0;
    n = 0;
    while (streak < 3 && n < 400) begin
      @(negedge CLK);
      n++;
      streak = BUSY ? 0 : streak + 1;
    end
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    while (!(INC_SENS || RED_SENS) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_pulse"}, 32'(INC_SENS || RED_SENS), 32'd1);
  endtask

  function automatic logic [7:0] stat(bit b, bit e, bit d, int t, int s);
    return {b, e, d, 1'b0, 2'(t), 2'(s)};
  endfunction

  initial begin
    logic [7:0] rd;
    int i0, r0, n, s, t1, t2, p, ei, er, fin;
    bit retgt, seen;

    // Reset
    set_sens(1);
    cyc(3);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_raise", 32'(BUS_INTERRUPT_RAISE), 0);
    chk("rst_pulse", 32'(INC_SENS || RED_SENS), 0);
    RESET = 1'b1;
    cyc(1);
    bus_rd(8'hA7, rd); chk("rst_status", 32'(rd), 32'h01);
    bus_rd(8'hA6, rd); chk("rst_target", 32'(rd), 32'h00);
    cyc(5);
    chk("rst_nopulse", 32'(inc_cnt + red_cnt), 0);

    // 1 -> 3, upper data bits ignored
    i0 = inc_cnt; r0 = red_cnt;
    bus_wr(8'hA6, 8'hFF);
    wait_idle("up");
    chk("up_inc", 32'(inc_cnt - i0), 2);
    chk("up_red", 32'(red_cnt - r0), 0);
    bus_rd(8'hA7, rd); chk("up_status", 32'(rd), 32'h2F);
    chk("up_raise", 32'(BUS_INTERRUPT_RAISE), 1);
    BUS_INTERRUPTS_ACK = 2'b01; cyc(1); BUS_INTERRUPTS_ACK = 2'b00;
    chk("up_wrong_ack", 32'(BUS_INTERRUPT_RAISE), 1);
    ack();
    chk("up_acked", 32'(BUS_INTERRUPT_RAISE), 0);

    // 2 -> 0
    set_sens(2);
    i0 = inc_cnt; r0 = red_cnt;
    bus_wr(8'hA6, 8'h00);
    wait_idle("dn");
    chk("dn_red", 32'(red_cnt - r0), 2);
    chk("dn_inc", 32'(inc_cnt - i0), 0);
    bus_rd(8'hA7, rd); chk("dn_status", 32'(rd), 32'h20);
    bus_wr(8'hA7, 8'h00);
    bus_rd(8'hA7, rd); chk("dn_clr", 32'(rd), 32'h00);
    ack();

    // Timeout: transceiver ignores the step
    respond = 1'b0;
    set_sens(0);
    i0 = inc_cnt;
    bus_wr(8'hA6, 8'h02);
    wait_pulse("tmo");
    n = 0;
    while (!BUS_INTERRUPT_RAISE && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'(TMO + 2));
    wait_idle("tmo");
    chk("tmo_inc", 32'(inc_cnt - i0), 1);
    bus_rd(8'hA7, rd); chk("tmo_status", 32'(rd), 32'h48);
    chk("tmo_raise", 32'(BUS_INTERRUPT_RAISE), 1);
    bus_wr(8'hA7, 8'h00);
    bus_rd(8'hA7, rd); chk("tmo_clr", 32'(rd), 32'h08);
    ack();
    respond = 1'b1;

    // Retarget 1 -> 3 after the first step
    set_sens(0);
    i0 = inc_cnt; r0 = red_cnt;
    bus_wr(8'hA6, 8'h01);
    wait_pulse("rt");
    bus_wr(8'hA6, 8'h03);
    wait_idle("rt");
    chk("rt_inc", 32'(inc_cnt - i0), 3);
    chk("rt_red", 32'(red_cnt - r0), 0);
    bus_rd(8'hA7, rd); chk("rt_status", 32'(rd), 32'h2F);
    ack();
    bus_wr(8'hA7, 8'h00);

    // Reset during WAIT
    set_sens(0);
    bus_wr(8'hA6, 8'h03);
    wait_pulse("mr");
    cyc(2);
    RESET = 1'b0;
    cyc(1);
    chk("mr_busy", 32'(BUSY), 0);
    chk("mr_raise", 32'(BUS_INTERRUPT_RAISE), 0);
    cyc(1);
    RESET = 1'b1;
    i0 = inc_cnt; r0 = red_cnt;
    bus_rd(8'hA6, rd); chk("mr_target", 32'(rd), 32'h00);
    cyc(30);
    chk("mr_nopulse", 32'((inc_cnt - i0) + (red_cnt - r0)), 0);

    // Ack held across the completion: set wins for one cycle
    set_sens(0);
    BUS_INTERRUPTS_ACK = 2'b10;
    bus_wr(8'hA6, 8'h01);
    seen = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge CLK);
      n++;
      if (BUSY) seen = 1'b1;
      else if (seen) break;
    end
    chk("coll_set", 32'(BUS_INTERRUPT_RAISE), 1);
    cyc(1);
    chk("coll_clr", 32'(BUS_INTERRUPT_RAISE), 0);
    BUS_INTERRUPTS_ACK = 2'b00;

    // Randomized targets with optional mid-sequence retarget
    for (int k = 0; k < 40; k++) begin
      ack();
      bus_wr(8'hA7, 8'h00);
      s  = int'($urandom_range(0, 3));
      t1 = int'($urandom_range(0, 3));
      retgt = (t1 != s) && ($urandom_range(0, 1) == 1);
      set_sens(s);
      i0 = inc_cnt; r0 = red_cnt;
      bus_wr(8'hA6, {6'($urandom_range(0, 63)), 2'(t1)});
      if (retgt) begin
        wait_pulse("rnd");
        t2 = int'($urandom_range(0, 3));
        bus_wr(8'hA6, 8'(t2));
        p   = (t1 > s) ? s + 1 : s - 1;
        ei  = ((t1 > s) ? 1 : 0) + ((t2 > p) ? t2 - p : 0);
        er  = ((t1 < s) ? 1 : 0) + ((p > t2) ? p - t2 : 0);
        fin = t2;
      end else begin
        ei  = (t1 > s) ? t1 - s : 0;
        er  = (s > t1) ? s - t1 : 0;
        fin = t1;
      end
      wait_idle("rnd");
      chk("rnd_inc", 32'(inc_cnt - i0), 32'(ei));
      chk("rnd_red", 32'(red_cnt - r0), 32'(er));
      bus_rd(8'hA7, rd); chk("rnd_status", 32'(rd), 32'(stat(1'b0, 1'b0, 1'b1, fin, fin)));
      chk("rnd_raise", 32'(BUS_INTERRUPT_RAISE), 1);
    end

    chk("no_overlap", 32'(both_seen), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/mouse_sens_ctrl.md
Name: mouse_sens_ctrl

Overview:
Bus-mapped controller that lets software set mouse sensitivity. The processor writes a target level. The block steps the transceiver's sensitivity up or down with single-cycle INC/RED pulses, one step at a time, waiting for each change to be reflected before the next step. On completion or timeout it raises a bus interrupt. It sits beside the mouse IO peripheral on the shared 8-bit data bus.

Parameters:
BASE_ADDR, 8'hA6, address of TARGET register; STATUS register is BASE_ADDR+1.
TIMEOUT_CYCLES, 24'd10_000_000, max cycles to wait for a step to take effect (100 ms at 100 MHz).
INT_IDX, 1, index of BUS_INTERRUPTS_ACK bit that clears this block's interrupt.

Ports:
CLK  in  1  system clock, all logic on posedge
RESET  in  1  synchronous reset, active-low (port keeps codebase name RESET; asserted when 0)
BUS_DATA  inout  8  shared data bus, tristated when not driving
BUS_ADDR  in  8  bus address
BUS_WE  in  1  1 = processor write, 0 = read
SENS_CUR  in  2  current sensitivity reported by mouse transceiver
INC_SENS  out  1  one-cycle pulse: transceiver raises sensitivity one step
RED_SENS  out  1  one-cycle pulse: transceiver lowers sensitivity one step
BUS_INTERRUPT_RAISE  out  1  level interrupt request
BUS_INTERRUPTS_ACK  in  2  interrupt acknowledge bits from processor
BUSY  out  1  high while FSM not in IDLE

Behaviour:
- Reset (RESET=0 at posedge): FSM=IDLE; TARGET=0; pending=0; done=0; err=0; timer=0; INC_SENS=RED_SENS=0; BUS_INTERRUPT_RAISE=0; BUSY=0; bus not driven.
- Write: when BUS_WE=1 and BUS_ADDR==BASE_ADDR at posedge, TARGET<=BUS_DATA[1:0] and pending<=1. BUS_DATA[7:2] are ignored.
- Write to BASE_ADDR+1 clears done and err. A set of done/err in the same cycle wins over the clear.
- Read: registered, same as other bus peripherals. In cycle N, address in range and BUS_WE=0. Data and drive-enable are registered at that edge, so BUS_DATA is driven during cycle N+1; it is Z otherwise.
- Read data at BASE_ADDR: {6'b0, TARGET}.
- Read data at BASE_ADDR+1: {BUSY, err, done, 1'b0, TARGET, SENS_CUR}.
- FSM states: IDLE, COMPARE, ISSUE, WAIT, FINISH, ERROR.
- IDLE: if pending, clear pending and go to COMPARE.
- COMPARE: if TARGET==SENS_CUR, go to FINISH. Otherwise latch snap<=SENS_CUR and dir<=(TARGET>SENS_CUR), then go to ISSUE.
- ISSUE: assert INC_SENS if dir, else RED_SENS, for exactly this one cycle. Load timer<=TIMEOUT_CYCLES-1, go to WAIT.
- WAIT: if SENS_CUR!=snap, go to COMPARE. Else if timer==0, go to ERROR. Else decrement timer.
- FINISH: done<=1; set interrupt; go to IDLE.
- ERROR: err<=1; set interrupt; go to IDLE.
- Maximum steps is 3 (0→3 or 3→0). At most one pulse is outstanding; INC_SENS and RED_SENS are never high together.
- A TARGET write while BUSY updates TARGET and sets pending. The active sequence steers toward the new target at its next COMPARE. After FINISH/ERROR, the pending flag causes one further COMPARE pass, which finishes immediately if already at target.
- A write in the same cycle IDLE consumes pending: pending stays 1 (set wins).
- Interrupt: BUS_INTERRUPT_RAISE is set in FINISH/ERROR and cleared when BUS_INTERRUPTS_ACK[INT_IDX]=1. Set wins on simultaneous set and ack.
- Reset mid-sequence aborts immediately to reset values. No pulse is emitted in the reset cycle.
- Timer width is 24 bits. TIMEOUT_CYCLES must be ≥2.

Decomposition:
- Shared package mouse_pkg:
  - FSM state encoding (3-bit enum).
  - Bus address constants: MOUSE_BASE 8'hA0, SENS_BASE 8'hA6.
  - STATUS bit indices.
  - Interrupt index constants.
- One natural sub-module, bus_reg_port: registered read mux plus tristate driver plus address decode. It is reusable by other bus peripherals. The FSM and timer stay in the top module.

Test Plan:
- Reset, then hold SENS_CUR=1 and read 0xA7 → bus reads 8'h01 one cycle after address; no pulses; RAISE=0.
- Write 0xA6=3 with SENS_CUR=1; model increments SENS_CUR 5 cycles after each INC pulse → exactly 2 INC_SENS pulses, 0 RED_SENS; STATUS=8'h2F; RAISE=1 until ACK[1] pulse, then 0.
- Write 0xA6=0 with SENS_CUR=2 → 2 RED_SENS pulses; done=1; BUSY low after FINISH.
- TIMEOUT_CYCLES=16, SENS_CUR never changes, write target 2 from 0 → one INC pulse; ERROR state 16 cycles after WAIT entry; err=1 in STATUS; RAISE=1; write 0xA7 clears err.
- Write target 3 mid-sequence (from 0, after first INC) while target was 1 → sequence continues to 3 with 3 total INC pulses; single extra COMPARE pass gives no extra pulse.
- Assert RESET=0 during WAIT → next cycle BUSY=0, RAISE=0, TARGET=0; no further pulses after release; ACK and set in same cycle leaves RAISE=1.
